fd_pipe_ctrl: RTL

//  Sequencer for the fetch/decode pipeline latch and PC. Each cycle it decides

---
 rtl/fd_pipe_ctrl.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/fd_pipe_ctrl.sv
// fd_pipe_ctrl: fetch/decode sequencer. It drives the PC enable, the F/D latch
// enable and flush, the D/X bubble insert and the back-end enable. It handles
// branch redirect, load-use hazards, multi-cycle fetch, data-memory stall and HALT.
// Optional macro STALL_STATS_EN adds saturating stall-statistics counters.
// Without the macro, ld_cnt, miss_cnt and flush_cnt are tied to zero.
module fd_pipe_ctrl #(
  parameter int REG_W = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             imem_done,
  input  logic             dmem_stall,
  input  logic             br_taken_x,
  input  logic             memrd_x,
  input  logic [REG_W-1:0] rd_x,
  input  logic [REG_W-1:0] rs_d,
  input  logic [REG_W-1:0] rt_d,
  input  logic             use_rs_d,
  input  logic             use_rt_d,
  input  logic             halt_d,
  output logic             pc_en,
  output logic             fd_en,
  output logic             fd_flush,
  output logic             dx_bubble,
  output logic             back_en,
  output logic             halted,
  output logic [CNT_W-1:0] ld_cnt,
  output logic [CNT_W-1:0] miss_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LDSTALL = 2'd1,
    IWAIT   = 2'd2,
    HALTED  = 2'd3
  } state_t;

  state_t state_q, state_d;
  logic   cancel_q, cancel_d;
  logic   done_pend_q;
  logic   done;
  logic   hazard;
  logic   redirect;
  logic   ld_entry;

  // A fetch completion seen during a data stall is remembered and used later.
  assign done   = imem_done | done_pend_q;
  assign hazard = memrd_x && ((use_rs_d && (rs_d == rd_x)) ||
                              (use_rt_d && (rt_d == rd_x)));

  // State, cancel flag, pending-done flag and halted indication.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      cancel_q    <= 1'b0;
      done_pend_q <= 1'b0;
      halted      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cancel_q    <= cancel_d;
      done_pend_q <= dmem_stall ? (done_pend_q | imem_done) : 1'b0;
      halted      <= (state_d == HALTED);
    end
  end

  // Next-state and per-cycle enables. A data stall freezes everything.
  always_comb begin
    state_d   = state_q;
    cancel_d  = cancel_q;
    pc_en     = 1'b0;
    fd_en     = 1'b0;
    fd_flush  = 1'b0;
    dx_bubble = 1'b0;
    back_en   = 1'b1;
    redirect  = 1'b0;
    ld_entry  = 1'b0;
    if (dmem_stall) begin
      back_en = 1'b0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (br_taken_x) begin
            pc_en    = 1'b1;
            fd_en    = 1'b1;
            fd_flush = 1'b1;
            redirect = 1'b1;
            cancel_d = 1'b0;
            state_d  = IWAIT;
          end else if (halt_d) begin
            state_d = HALTED;
          end else if (hazard) begin
            dx_bubble = 1'b1;
            ld_entry  = 1'b1;
            state_d   = LDSTALL;
          end else if (!done) begin
            fd_en    = 1'b1;
            fd_flush = 1'b1;
            state_d  = IWAIT;
          end else begin
            pc_en = 1'b1;
            fd_en = 1'b1;
          end
        end
        LDSTALL: begin
          pc_en = 1'b1;
          fd_en = 1'b1;
          if (br_taken_x) begin
            fd_flush = 1'b1;
            redirect = 1'b1;
            cancel_d = 1'b0;
            state_d  = IWAIT;
          end else begin
            state_d = RUN;
          end
        end
        IWAIT: begin
          fd_en = 1'b1;
          if (br_taken_x) begin
            // The outstanding fetch is wrong-path: take the target now and
            // throw away whatever that fetch returns.
            pc_en    = 1'b1;
            fd_flush = 1'b1;
            redirect = 1'b1;
            cancel_d = 1'b1;
          end else if (done && !cancel_q) begin
            pc_en   = 1'b1;
            state_d = RUN;
          end else if (done) begin
            fd_flush = 1'b1;
            cancel_d = 1'b0;
          end else begin
            fd_flush = 1'b1;
          end
        end
        HALTED: begin
          pc_en = 1'b0;
          fd_en = 1'b0;
        end
        default: state_d = RUN;
      endcase
    end
  end

`ifdef STALL_STATS_EN
  // Saturating statistics, frozen while the data memory stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_cnt    <= '0;
      miss_cnt  <= '0;
      flush_cnt <= '0;
    end else if (!dmem_stall) begin
      if (ld_entry && (ld_cnt != '1))
        ld_cnt <= ld_cnt + 1'b1;
      if ((state_q == IWAIT) && (miss_cnt != '1))
        miss_cnt <= miss_cnt + 1'b1;
      if (redirect && (flush_cnt != '1))
        flush_cnt <= flush_cnt + 1'b1;
    end
  end
`else
  logic unused_stats;
  assign unused_stats = redirect ^ ld_entry;
  assign ld_cnt       = '0;
  assign miss_cnt     = '0;
  assign flush_cnt    = '0;
`endif

endmodule
